// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration sequencer.
// Command word field positions, opcodes and FSM states.
package frame_cfg_pkg;

    localparam logic [3:0] OP_NOP         = 4'h0;
    localparam logic [3:0] OP_WRITE_FRAME = 4'h1;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int COL_HI = 27;
    localparam int COL_LO = 20;
    localparam int FRM_HI = 19;
    localparam int FRM_LO = 12;

    localparam int STB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// One-hot decode of {col, frame, enable} into the column-major
// FrameStrobe vector; bit c*MaxFramesPerCol+f selects column c frame f.
module frame_strobe_decoder #(
    parameter int NumCols         = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [7:0]                         i_col,
    input  logic [7:0]                         i_frame,
    input  logic                               i_en,
    output logic [NumCols*MaxFramesPerCol-1:0] o_strobe
);

    for (genvar c = 0; c < NumCols; c++) begin : g_col
        for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frm
            assign o_strobe[c*MaxFramesPerCol+f] =
                i_en & (i_col == 8'(c)) & (i_frame == 8'(f));
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream command sequencer: loads one data word per tile row,
// then strobes the addressed column/frame for StrobeCycles cycles.
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4,
    parameter int NumCols         = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [31:0]                          s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 cmd_error,
    output logic [15:0]                          frames_written
);

    localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [RW-1:0]        LAST_ROW = RW'(NumRows - 1);
    localparam logic [7:0]           COL_LIM  = 8'(NumCols);
    localparam logic [7:0]           FRM_LIM  = 8'(MaxFramesPerCol);
    localparam logic [STB_CNT_W-1:0] STB_LAST = STB_CNT_W'(StrobeCycles - 1);

    seq_state_t                         r_state;
    logic [RW-1:0]                      r_row;
    logic [7:0]                         r_col;
    logic [7:0]                         r_frame;
    logic [STB_CNT_W-1:0]               r_stb_cnt;
    logic [NumRows*FrameBitsPerRow-1:0] r_frame_data;
    logic                               r_cmd_error;
    logic [15:0]                        r_frames_written;

    logic [3:0] w_opcode;
    logic [7:0] w_col;
    logic [7:0] w_frame;
    logic       w_in_range;

    assign w_opcode   = s_data[OPC_HI:OPC_LO];
    assign w_col      = s_data[COL_HI:COL_LO];
    assign w_frame    = s_data[FRM_HI:FRM_LO];
    assign w_in_range = (w_col < COL_LIM) && (w_frame < FRM_LIM);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state          <= IDLE;
            r_row            <= '0;
            r_col            <= '0;
            r_frame          <= '0;
            r_stb_cnt        <= '0;
            r_frame_data     <= '0;
            r_cmd_error      <= 1'b0;
            r_frames_written <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        if (w_opcode == OP_WRITE_FRAME && w_in_range) begin
                            r_col   <= w_col;
                            r_frame <= w_frame;
                            r_row   <= '0;
                            r_state <= LOAD;
                        end else if (w_opcode != OP_NOP) begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        r_frame_data[r_row*FrameBitsPerRow +: FrameBitsPerRow]
                            <= s_data[FrameBitsPerRow-1:0];
                        r_row <= r_row + 1'b1;
                        if (r_row == LAST_ROW) begin
                            r_stb_cnt <= STB_LAST;
                            r_state   <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    if (r_stb_cnt == '0) begin
                        r_state <= HOLD;
                    end else begin
                        r_stb_cnt <= r_stb_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    r_frames_written <= r_frames_written + 16'd1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so no word is consumed while aborting.
    assign s_ready = ~reset & ((r_state == IDLE) | (r_state == LOAD));
    assign busy    = (r_state != IDLE);

    frame_strobe_decoder #(
        .NumCols         (NumCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_dec (
        .i_col    (r_col),
        .i_frame  (r_frame),
        .i_en     (r_state == STROBE),
        .o_strobe (FrameStrobe)
    );

    assign FrameData      = r_frame_data;
    assign cmd_error      = r_cmd_error;
    assign frames_written = r_frames_written;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed self-checking bench for frame_config_sequencer.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_frame_config_sequencer;

    logic         CLK = 1'b0;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         busy;
    logic         cmd_error;
    logic [15:0]  frames_written;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          stb_cycles = 0;
    int          multi_hot = 0;
    int          rdy_low = 0;
    logic [79:0] stb_last = '0;
    logic [79:0] stb_or = '0;

    frame_config_sequencer dut (
        .CLK            (CLK),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .cmd_error      (cmd_error),
        .frames_written (frames_written)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            stb_cycles++;
            stb_last = FrameStrobe;
            stb_or   = stb_or | FrameStrobe;
        end
        if ($countones(FrameStrobe) > 1) multi_hot++;
        if (!s_ready && !reset) rdy_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        @(negedge CLK);
        s_valid = 1'b0;
        s_data  = 32'hBAD0_BAD0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("idle_timeout", 0, 1);
    endtask

    function automatic logic [31:0] wr_cmd(input int col, input int frm);
        return {4'h1, 8'(col), 8'(frm), 12'h000};
    endfunction

    task automatic write_frame(input int col, input int frm,
                               input logic [31:0] d [4]);
        send(wr_cmd(col, frm));
        for (int i = 0; i < 4; i++) send(d[i]);
    endtask

    logic [31:0]  d1 [4] = '{32'h11111111, 32'h22222222,
                             32'h33333333, 32'h44444444};
    logic [31:0]  d2 [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1,
                             32'hC2C2C2C2, 32'hD3D3D3D3};
    logic [31:0]  d3 [4] = '{32'h01234567, 32'h89ABCDEF,
                             32'hFEDCBA98, 32'h76543210};
    logic [31:0]  d4 [4] = '{32'hCAFEF00D, 32'h0000FFFF,
                             32'hFFFF0000, 32'h5A5A5A5A};
    int           gaps [4] = '{2, 0, 3, 1};
    logic [127:0] prev;
    logic [79:0]  one;
    int           s0, r0, t0;

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge CLK);
        check("rst_ready", s_ready, 0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("rst_data", FrameData, 0);
        check("rst_strobe", FrameStrobe, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cmd_error, 0);
        check("rst_cnt", frames_written, 0);
        check("idle_ready", s_ready, 1);

        // Basic write: column 2 frame 5 -> bit 45
        s0 = stb_cycles;
        r0 = rdy_low;
        write_frame(2, 5, d1);
        one = 80'd1 << 45;
        check("b_strobe_now", FrameStrobe, one);
        check("b_busy", busy, 1);
        wait_idle();
        check("b_data", FrameData, {d1[3], d1[2], d1[1], d1[0]});
        check("b_stb_cycles", stb_cycles - s0, 2);
        check("b_stb_bit", stb_last, one);
        check("b_stb_only", stb_or, one);
        check("b_rdy_low", rdy_low - r0, 3);
        check("b_count", frames_written, 1);
        check("b_idle_busy", busy, 0);

        // Illegal commands
        s0 = stb_cycles;
        send(32'h1040_0000);
        check("ill_col_err", cmd_error, 1);
        check("ill_col_ready", s_ready, 1);
        send(32'h1001_4000);
        send(32'h7000_0000);
        check("ill_busy", busy, 0);
        check("ill_ready", s_ready, 1);
        check("ill_no_stb", stb_cycles - s0, 0);
        check("ill_cnt", frames_written, 1);
        write_frame(1, 19, d2);
        wait_idle();
        check("ill_w_bit", stb_last, 80'd1 << 39);
        check("ill_w_cycles", stb_cycles - s0, 2);
        check("ill_w_data", FrameData, {d2[3], d2[2], d2[1], d2[0]});
        check("ill_err_sticky", cmd_error, 1);
        check("ill_w_cnt", frames_written, 2);

        // Gapped data words: column 3 frame 0 -> bit 60
        s0 = stb_cycles;
        r0 = rdy_low;
        send(wr_cmd(3, 0));
        for (int i = 0; i < 4; i++) begin
            s_data = 32'hDEAD0000 | 32'(i);
            repeat (gaps[i]) @(negedge CLK);
            if (i == 0)
                check("gap_keep_prev", FrameData,
                      {d2[3], d2[2], d2[1], d2[0]});
            send(d3[i]);
        end
        wait_idle();
        check("gap_data", FrameData, {d3[3], d3[2], d3[1], d3[0]});
        check("gap_bit", stb_last, 80'd1 << 60);
        check("gap_cycles", stb_cycles - s0, 2);
        check("gap_rdy_low", rdy_low - r0, 3);
        check("gap_cnt", frames_written, 3);

        // Reset in the first strobe cycle
        write_frame(0, 1, d4);
        check("rs_strobe_on", FrameStrobe, 80'd1 << 1);
        reset = 1'b1;
        @(negedge CLK);
        check("rs_strobe", FrameStrobe, 0);
        check("rs_data", FrameData, 0);
        check("rs_busy", busy, 0);
        check("rs_cnt", frames_written, 0);
        check("rs_err", cmd_error, 0);
        reset = 1'b0;
        @(negedge CLK);
        write_frame(2, 7, d1);
        wait_idle();
        check("rs_w_bit", stb_last, 80'd1 << 47);
        check("rs_w_data", FrameData, {d1[3], d1[2], d1[1], d1[0]});
        check("rs_w_cnt", frames_written, 1);

        // Three back-to-back frames with continuous valid
        s0 = stb_cycles;
        t0 = cyc;
        write_frame(0, 0, d2);
        write_frame(3, 19, d3);
        write_frame(1, 10, d4);
        wait_idle();
        check("tp_cycles", cyc - t0, 24);
        check("tp_stb", stb_cycles - s0, 6);
        check("tp_last", stb_last, 80'd1 << 30);
        check("tp_cnt", frames_written, 4);

        // NOPs interleaved between frames
        t0 = cyc;
        write_frame(0, 3, d1);
        send(32'h0000_0000);
        send(32'h0ABC_DEF1);
        write_frame(2, 2, d2);
        wait_idle();
        check("nop_cycles", cyc - t0, 18);
        check("nop_cnt", frames_written, 6);
        check("nop_err", cmd_error, 0);
        check("nop_data", FrameData, {d2[3], d2[2], d2[1], d2[0]});
        check("nop_bit", stb_last, 80'd1 << 42);

        // Counter wrap
        force dut.r_frames_written = 16'hFFFF;
        @(negedge CLK);
        release dut.r_frames_written;
        @(negedge CLK);
        check("wrap_pre", frames_written, 16'hFFFF);
        write_frame(3, 3, d3);
        wait_idle();
        check("wrap_cnt", frames_written, 0);
        check("multi_hot", multi_hot, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
